// File: rtl/bus_spm_slave.sv
`default_nettype none
// ============================================================================
// Module      : bus_spm_slave
// Description : Scratch-pad memory responder on the shared system bus.
//               Decodes a begin beat, checks the address window and either
//               streams read beats back or absorbs write beats with byte
//               enables, optionally inserting wait states. Out-of-window
//               accesses get a one-cycle bus error.
// Ports       : clock, nReset            - clock, async active-low reset
//               beginTransactionIn       - start strobe (address phase)
//               addressDataIn[31:0]      - byte address / write data
//               readNotWriteIn           - 1 = read, sampled with begin
//               byteEnablesIn[3:0]       - write lane enables, sampled with begin
//               burstSizeIn[7:0]         - beats minus one, sampled with begin
//               dataValidIn              - write beat valid
//               endTransactionIn         - initiator end / abort strobe
//               addressDataOut[31:0]     - read data, 0 when not valid
//               dataValidOut             - read beat valid
//               endTransactionOut        - end of read burst
//               busyOut                  - write wait state
//               busErrorOut              - error response
// Revision    : 1.0 - initial release
// ============================================================================
module bus_spm_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'hC000_0000,
    parameter int          ADDR_BITS    = 10,
    parameter int          READ_WAIT    = 0,
    parameter int          WRITE_WAIT   = 0
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic        readNotWriteIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busyOut,
    output logic        busErrorOut
);

    localparam int                  c_WORDS      = 1 << ADDR_BITS;
    localparam int                  c_TAG_LSB    = ADDR_BITS + 2;
    localparam logic [31:c_TAG_LSB] c_BASE_TAG   = BASE_ADDRESS[31:c_TAG_LSB];
    localparam logic [3:0]          c_READ_WAIT  = READ_WAIT[3:0];
    localparam logic [3:0]          c_WRITE_WAIT = WRITE_WAIT[3:0];

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_RD_BURST = 3'd2,
        S_RD_END   = 3'd3,
        S_WR       = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t                 r_state_q, w_state_d;
    logic [ADDR_BITS-1:0]   r_addr_q,  w_addr_d;    // current word index
    logic [ADDR_BITS-1:0]   r_last_q,  w_last_d;    // index of the final beat
    logic [3:0]             r_be_q,    w_be_d;
    logic [3:0]             r_wait_q,  w_wait_d;
    logic                   r_valid_q, w_valid_d;
    logic                   r_end_q,   w_end_d;
    logic                   r_busy_q,  w_busy_d;
    logic                   r_error_q, w_error_d;

    logic [31:0]            r_mem [c_WORDS];
    logic [31:0]            r_rdata_q;

    logic [ADDR_BITS-1:0]   w_begin_index;
    logic [ADDR_BITS+8:0]   w_last_index;
    logic                   w_tag_hit;
    logic                   w_range_ok;
    logic                   w_abort;
    logic                   w_wr_en;

    assign w_begin_index = addressDataIn[ADDR_BITS+1:2];
    assign w_tag_hit     = (addressDataIn[31:c_TAG_LSB] == c_BASE_TAG);
    // Computed wide so a burst running past the top of the window shows up
    // as a carry instead of silently wrapping to index 0.
    assign w_last_index  = {9'd0, w_begin_index}
                         + {{(ADDR_BITS+1){1'b0}}, burstSizeIn};
    assign w_range_ok    = (w_last_index[ADDR_BITS+8:ADDR_BITS] == '0);
    assign w_abort       = (r_state_q != S_IDLE) && endTransactionIn;

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_last_d  = r_last_q;
        w_be_d    = r_be_q;
        w_wait_d  = r_wait_q;
        w_valid_d = 1'b0;
        w_end_d   = 1'b0;
        w_busy_d  = 1'b0;
        w_error_d = 1'b0;
        w_wr_en   = 1'b0;

        if (w_abort) begin
            // Abort wins over everything: outputs drop next cycle and a
            // coinciding write beat is not committed.
            w_state_d = S_IDLE;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    if (beginTransactionIn) begin
                        w_addr_d = w_begin_index;
                        w_last_d = w_last_index[ADDR_BITS-1:0];
                        w_be_d   = byteEnablesIn;
                        if (!(w_tag_hit && w_range_ok)) begin
                            w_state_d = S_ERROR;
                            w_error_d = 1'b1;
                        end else if (readNotWriteIn) begin
                            if (c_READ_WAIT == 4'd0) begin
                                w_state_d = S_RD_BURST;
                            end else begin
                                w_state_d = S_RD_WAIT;
                                w_wait_d  = c_READ_WAIT - 4'd1;
                            end
                        end else begin
                            w_state_d = S_WR;
                            w_wait_d  = c_WRITE_WAIT;
                            w_busy_d  = (c_WRITE_WAIT != 4'd0);
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_wait_q == 4'd0) begin
                        w_state_d = S_RD_BURST;
                    end else begin
                        w_wait_d = r_wait_q - 4'd1;
                    end
                end
                S_RD_BURST: begin
                    // SRAM is addressed this cycle; its data and the valid
                    // flag both appear on the next cycle.
                    w_valid_d = 1'b1;
                    if (r_addr_q == r_last_q) begin
                        w_state_d = S_RD_END;
                    end else begin
                        w_addr_d = r_addr_q + 1'b1;
                    end
                end
                S_RD_END: begin
                    w_end_d   = 1'b1;
                    w_state_d = S_IDLE;
                end
                S_WR: begin
                    if (r_wait_q != 4'd0) begin
                        // busyOut reflects the count of the following cycle
                        w_wait_d = r_wait_q - 4'd1;
                        w_busy_d = (r_wait_q != 4'd1);
                    end else if (dataValidIn) begin
                        w_wr_en = 1'b1;
                        if (r_addr_q == r_last_q) begin
                            w_state_d = S_IDLE;
                        end else begin
                            w_addr_d = r_addr_q + 1'b1;
                            w_wait_d = c_WRITE_WAIT;
                            w_busy_d = (c_WRITE_WAIT != 4'd0);
                        end
                    end
                end
                S_ERROR: begin
                    w_state_d = S_IDLE;
                end
                default: begin
                    w_state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state_q <= S_IDLE;
            r_addr_q  <= '0;
            r_last_q  <= '0;
            r_be_q    <= '0;
            r_wait_q  <= '0;
            r_valid_q <= 1'b0;
            r_end_q   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_error_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_last_q  <= w_last_d;
            r_be_q    <= w_be_d;
            r_wait_q  <= w_wait_d;
            r_valid_q <= w_valid_d;
            r_end_q   <= w_end_d;
            r_busy_q  <= w_busy_d;
            r_error_q <= w_error_d;
        end
    end

    // Single-port SRAM, byte-write, registered read. Contents survive reset.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be_q[i]) begin
                    r_mem[r_addr_q][8*i +: 8] <= addressDataIn[8*i +: 8];
                end
            end
        end
        r_rdata_q <= r_mem[r_addr_q];
    end

    // The bus is OR-combined, so read data must be zero outside valid beats.
    assign addressDataOut    = r_valid_q ? r_rdata_q : 32'd0;
    assign dataValidOut      = r_valid_q;
    assign endTransactionOut = r_end_q;
    assign busyOut           = r_busy_q;
    assign busErrorOut       = r_error_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_spm_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_spm_slave
// Description : Scoreboard bench for bus_spm_slave. Two instances run in
//               parallel (no wait states; READ_WAIT=2/WRITE_WAIT=3). Drivers
//               push cycle-stamped expected responses computed from a word
//               array model; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_spm_slave;

    localparam logic [31:0] c_BASE  = 32'hC000_0000;
    localparam int          c_WORDS = 1024;
    localparam int          K_RD    = 0;
    localparam int          K_END   = 1;
    localparam int          K_BUSY  = 2;
    localparam int          K_ERR   = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clock  = 1'b0;
    logic nReset = 1'b0;
    always #5 clock = ~clock;

    logic        beg [2];
    logic [31:0] adi [2];
    logic        rnw [2];
    logic [3:0]  bei [2];
    logic [7:0]  bsz [2];
    logic        dvi [2];
    logic        eti [2];
    logic [31:0] ado [2];
    logic        dvo [2];
    logic        eto [2];
    logic        bso [2];
    logic        ero [2];

    logic [31:0] model_mem [2][c_WORDS];
    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc         = 0;
    int          vectors     = 0;
    int          miscompares = 0;
    bit          mon_en      = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    bus_spm_slave #(.BASE_ADDRESS(c_BASE), .ADDR_BITS(10), .READ_WAIT(0), .WRITE_WAIT(0)) u_dut0 (
        .clock(clock), .nReset(nReset),
        .beginTransactionIn(beg[0]), .addressDataIn(adi[0]), .readNotWriteIn(rnw[0]),
        .byteEnablesIn(bei[0]), .burstSizeIn(bsz[0]), .dataValidIn(dvi[0]),
        .endTransactionIn(eti[0]), .addressDataOut(ado[0]), .dataValidOut(dvo[0]),
        .endTransactionOut(eto[0]), .busyOut(bso[0]), .busErrorOut(ero[0])
    );

    bus_spm_slave #(.BASE_ADDRESS(c_BASE), .ADDR_BITS(10), .READ_WAIT(2), .WRITE_WAIT(3)) u_dut1 (
        .clock(clock), .nReset(nReset),
        .beginTransactionIn(beg[1]), .addressDataIn(adi[1]), .readNotWriteIn(rnw[1]),
        .byteEnablesIn(bei[1]), .burstSizeIn(bsz[1]), .dataValidIn(dvi[1]),
        .endTransactionIn(eti[1]), .addressDataOut(ado[1]), .dataValidOut(dvo[1]),
        .endTransactionOut(eto[1]), .busyOut(bso[1]), .busErrorOut(ero[1])
    );

    // ------------------------------------------------------------ scoreboard
    function automatic void push_exp(int d, int kind, int c, logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = data;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    function automatic int q_size(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_front(int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_drop(int d);
        if (d == 0) q0.delete(0); else q1.delete(0);
    endfunction

    function automatic string kind_name(int k);
        case (k)
            K_RD:    return "read_beat";
            K_END:   return "end_txn";
            K_BUSY:  return "busy";
            default: return "bus_error";
        endcase
    endfunction

    task automatic drain_missed(int d);
        exp_t e;
        while (q_size(d) > 0) begin
            e = q_front(d);
            if (e.cyc >= cyc) break;
            q_drop(d);
            vectors++;
            miscompares++;
            $display("FAIL dut%0d missing_%s: got nothing, required at cycle %0d (data %h), now cycle %0d",
                     d, kind_name(e.kind), e.cyc, e.data, cyc);
        end
    endtask

    task automatic check_out(int d, int kind, logic [31:0] data);
        exp_t e;
        vectors++;
        if (q_size(d) == 0) begin
            miscompares++;
            $display("FAIL dut%0d %s: got output at cycle %0d (data %h), required none",
                     d, kind_name(kind), cyc, data);
            return;
        end
        e = q_front(d);
        q_drop(d);
        if (e.kind != kind || e.cyc != cyc || (kind == K_RD && data !== e.data)) begin
            miscompares++;
            $display("FAIL dut%0d %s: got %s at cycle %0d data %h, required %s at cycle %0d data %h",
                     d, kind_name(kind), kind_name(kind), cyc, data, kind_name(e.kind), e.cyc, e.data);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                drain_missed(d);
                if (dvo[d] === 1'b1) begin
                    check_out(d, K_RD, ado[d]);
                end else begin
                    vectors++;
                    if (ado[d] !== 32'd0 || dvo[d] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL dut%0d idle_bus: got data %h valid %b at cycle %0d, required 0/0",
                                 d, ado[d], dvo[d], cyc);
                    end
                end
                if (eto[d] !== 1'b0) check_out(d, K_END,  32'd0);
                if (bso[d] !== 1'b0) check_out(d, K_BUSY, 32'd0);
                if (ero[d] !== 1'b0) check_out(d, K_ERR,  32'd0);
            end
        end
    end

    // ----------------------------------------------------------------- model
    function automatic bit in_window(logic [31:0] addr, int bs);
        longint a, lo, hi;
        a  = longint'({32'd0, addr}) & ~longint'(3);
        lo = longint'({32'd0, c_BASE});
        hi = lo + 4 * c_WORDS;
        return (a >= lo) && (a + 4 * longint'(bs) < hi);
    endfunction

    // --------------------------------------------------------------- drivers
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic txn(int d, logic [31:0] addr, logic r, logic [3:0] be, int bs,
                       bit use_fixed, logic [31:0] fixed_data);
        int          t0, idx, rw, ww, beat, wait_left;
        logic [31:0] wd;
        rw  = (d == 0) ? 0 : 2;
        ww  = (d == 0) ? 0 : 3;
        t0  = cyc;
        idx = int'((addr - c_BASE) >> 2);
        beg[d] = 1'b1;
        adi[d] = addr;
        rnw[d] = r;
        bei[d] = be;
        bsz[d] = 8'(bs);
        if (!in_window(addr, bs)) begin
            push_exp(d, K_ERR, t0 + 1, 32'd0);
            next_cycle();
            beg[d] = 1'b0;
            adi[d] = $urandom;
            next_cycle();
            adi[d] = 32'd0;
        end else if (r) begin
            for (int n = 0; n <= bs; n++)
                push_exp(d, K_RD, t0 + 2 + rw + n, model_mem[d][idx + n]);
            push_exp(d, K_END, t0 + 3 + rw + bs, 32'd0);
            next_cycle();
            beg[d] = 1'b0;
            while (cyc < t0 + 3 + rw + bs) next_cycle();
        end else begin
            next_cycle();
            beg[d]    = 1'b0;
            beat      = 0;
            wait_left = ww;
            while (beat <= bs) begin
                wd     = use_fixed ? fixed_data + 32'(beat) : $urandom;
                adi[d] = wd;
                if (wait_left > 0) begin
                    push_exp(d, K_BUSY, cyc, 32'd0);
                    dvi[d] = 1'($urandom_range(0, 1));
                    wait_left--;
                end else begin
                    dvi[d] = ($urandom_range(0, 3) != 0);
                    if (dvi[d]) begin
                        for (int i = 0; i < 4; i++)
                            if (be[i]) model_mem[d][idx + beat][8*i +: 8] = wd[8*i +: 8];
                        beat++;
                        wait_left = ww;
                    end
                end
                next_cycle();
            end
            dvi[d] = 1'b0;
            adi[d] = 32'd0;
        end
    endtask

    task automatic rand_txn(int d);
        int          sel, bs, idx;
        logic [31:0] addr;
        sel = int'($urandom_range(0, 9));
        bs  = int'($urandom_range(0, 7));
        if (sel == 0) begin
            addr = $urandom;
        end else if (sel == 1) begin
            idx  = int'($urandom_range(c_WORDS - 8, c_WORDS - 1));
            bs   = int'($urandom_range(0, 15));
            addr = c_BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
        end else begin
            idx  = int'($urandom_range(0, c_WORDS - 1 - bs));
            addr = c_BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
        end
        txn(d, addr, 1'($urandom_range(0, 1)), 4'($urandom), bs, 1'b0, 32'd0);
    endtask

    // dut1 only: burst write of two beats, aborted while beat 1 waits.
    task automatic write_abort();
        int t0;
        t0     = cyc;
        beg[1] = 1'b1;
        adi[1] = c_BASE + 32'h100;
        rnw[1] = 1'b0;
        bei[1] = 4'hF;
        bsz[1] = 8'd1;
        for (int c = 1; c <= 3; c++) push_exp(1, K_BUSY, t0 + c, 32'd0);
        push_exp(1, K_BUSY, t0 + 5, 32'd0);
        push_exp(1, K_BUSY, t0 + 6, 32'd0);
        next_cycle();
        beg[1] = 1'b0;
        dvi[1] = 1'b1;
        while (cyc < t0 + 4) begin
            adi[1] = $urandom;
            next_cycle();
        end
        adi[1] = 32'h5555_AAAA;
        model_mem[1][64] = 32'h5555_AAAA;
        next_cycle();
        adi[1] = $urandom;
        next_cycle();
        eti[1] = 1'b1;
        adi[1] = 32'h1234_5678;
        next_cycle();
        eti[1] = 1'b0;
        dvi[1] = 1'b0;
        adi[1] = 32'd0;
    endtask

    // dut0 only: 8-beat read cut short by reset after two beats.
    task automatic reset_mid_burst();
        int t0;
        t0     = cyc;
        beg[0] = 1'b1;
        adi[0] = c_BASE + 32'h200;
        rnw[0] = 1'b1;
        bei[0] = 4'hF;
        bsz[0] = 8'd7;
        push_exp(0, K_RD, t0 + 2, model_mem[0][128]);
        push_exp(0, K_RD, t0 + 3, model_mem[0][129]);
        next_cycle();
        beg[0] = 1'b0;
        while (cyc < t0 + 4) next_cycle();
        #2;
        nReset = 1'b0;
        #1;
        vectors++;
        if (dvo[0] !== 1'b0 || ado[0] !== 32'd0 || eto[0] !== 1'b0 || bso[0] !== 1'b0 || ero[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_burst: got valid %b data %h end %b busy %b err %b, required all 0",
                     dvo[0], ado[0], eto[0], bso[0], ero[0]);
        end
        next_cycle();
        next_cycle();
        nReset = 1'b1;
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        for (int d = 0; d < 2; d++) begin
            beg[d] = 1'b0; adi[d] = 32'd0; rnw[d] = 1'b0; bei[d] = 4'h0;
            bsz[d] = 8'd0; dvi[d] = 1'b0; eti[d] = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (dvo[d] !== 1'b0 || ado[d] !== 32'd0 || eto[d] !== 1'b0 || bso[d] !== 1'b0 || ero[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL dut%0d reset_state: got valid %b data %h end %b busy %b err %b, required all 0",
                         d, dvo[d], ado[d], eto[d], bso[d], ero[d]);
            end
        end
        nReset = 1'b1;
        mon_en = 1'b1;
        next_cycle();

        fork
            begin
                for (int k = 0; k < 4; k++)
                    txn(0, c_BASE + 32'(k * 1024), 1'b0, 4'hF, 255, 1'b0, 32'd0);
                txn(0, 32'hC000_0010, 1'b0, 4'hF, 0, 1'b1, 32'hDEAD_BEEF);
                txn(0, 32'hC000_0010, 1'b1, 4'hF, 0, 1'b0, 32'd0);
                txn(0, 32'hC000_0020, 1'b0, 4'hF, 0, 1'b1, 32'hAAAA_AAAA);
                txn(0, 32'hC000_0020, 1'b0, 4'b0011, 0, 1'b1, 32'h1122_3344);
                txn(0, 32'hC000_0020, 1'b1, 4'hF, 0, 1'b0, 32'd0);
                txn(0, 32'hC000_1000, 1'b1, 4'hF, 0, 1'b0, 32'd0);
                txn(0, 32'hC000_0FFC, 1'b1, 4'hF, 1, 1'b0, 32'd0);
                txn(0, 32'hC000_0FF8, 1'b0, 4'hF, 2, 1'b0, 32'd0);
                txn(0, 32'hBFFF_FFFC, 1'b0, 4'hF, 0, 1'b0, 32'd0);
                txn(0, 32'hC000_0FF8, 1'b1, 4'hF, 1, 1'b0, 32'd0);
                for (int k = 0; k < 40; k++) rand_txn(0);
            end
            begin
                for (int k = 0; k < 4; k++)
                    txn(1, c_BASE + 32'(k * 1024), 1'b0, 4'hF, 255, 1'b0, 32'd0);
                txn(1, 32'hC000_0FF0, 1'b0, 4'hF, 3, 1'b1, 32'd1);
                txn(1, 32'hC000_0FF0, 1'b1, 4'hF, 3, 1'b0, 32'd0);
                write_abort();
                txn(1, 32'hC000_0100, 1'b1, 4'hF, 1, 1'b0, 32'd0);
                txn(1, 32'hC000_1000, 1'b1, 4'hF, 0, 1'b0, 32'd0);
                for (int k = 0; k < 40; k++) rand_txn(1);
            end
        join

        reset_mid_burst();
        txn(0, 32'hC000_0204, 1'b1, 4'hF, 3, 1'b0, 32'd0);
        txn(0, 32'hC000_0300, 1'b0, 4'b1010, 2, 1'b0, 32'd0);
        txn(0, 32'hC000_0300, 1'b1, 4'hF, 2, 1'b0, 32'd0);

        repeat (6) next_cycle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (q_size(d) != 0) begin
                miscompares++;
                $display("FAIL dut%0d leftover_expectations: got %0d outstanding, required 0", d, q_size(d));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        vectors++;
        miscompares++;
        $display("FAIL watchdog: still running at cycle %0d, required to have finished", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_spm_slave.md
# bus_spm_slave

Bus responder that backs a word-addressed scratch-pad memory on the shared system bus, serving single-word and burst reads and writes issued by initiators such as the data cache. It decodes the begin-transaction beat, checks the address window, then either streams read data back with `dataValidOut`/`endTransactionOut` or absorbs write beats with byte enables, inserting optional wait states via `busyOut`. It raises `busErrorOut` on out-of-window accesses.

## Interface
- `BASE_ADDRESS`, 32'hC0000000: byte base of the window; aligned to the window size.
- `ADDR_BITS`, 10: word-address width; the window is 2^ADDR_BITS words (4 KB by default).
- `READ_WAIT`, 0: extra idle cycles between begin and the first read beat (0-15).
- `WRITE_WAIT`, 0: `busyOut` cycles before each write beat is accepted (0-15).

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `beginTransactionIn` in 1: one-cycle start strobe from the granted initiator.
- `addressDataIn` in 32: byte address in the begin cycle, write data in beat cycles.
- `readNotWriteIn` in 1: 1 = read; sampled with begin.
- `byteEnablesIn` in 4: write lane enables, sampled with begin. Bit i covers data[8i+7:8i].
- `burstSizeIn` in 8: beats minus one, sampled with begin.
- `dataValidIn` in 1: write beat valid from the initiator.
- `endTransactionIn` in 1: initiator end or abort strobe.
- `addressDataOut` out 32: read data; 0 whenever `dataValidOut`=0, because the bus is OR-combined.
- `dataValidOut` out 1: read beat valid.
- `endTransactionOut` out 1: one-cycle end of a read burst.
- `busyOut` out 1: write wait state.
- `busErrorOut` out 1: one-cycle error response.

## Operation
- **Memory and addressing**
  - Internal synchronous SRAM is 2^ADDR_BITS x 32 with per-byte write enables and a 1-cycle read.
  - Word index = `addressDataIn[ADDR_BITS+1:2]`. Address bits [1:0] are ignored.
- **Decode at begin** (IDLE and `beginTransactionIn`=1): latch the word index, burst count, byte enables and direction.
  - Hit requires `addressDataIn[31:ADDR_BITS+2]` == `BASE_ADDRESS[31:ADDR_BITS+2]`.
  - Hit also requires (index + burstSize) < 2^ADDR_BITS, computed ADDR_BITS+1 wide. No wrap-around is allowed.
  - A miss goes to ERROR.
- **States**
  - IDLE: waits for `beginTransactionIn`. In IDLE, `endTransactionIn` and `dataValidIn` are ignored.
  - RD_WAIT: counts down READ_WAIT cycles. Skipped when READ_WAIT=0.
  - RD_BURST: presents SRAM address index+n each cycle for beats n=0..burstSize. The data is driven the following cycle with `dataValidOut`=1.
  - RD_END: `endTransactionOut`=1 for one cycle, then IDLE.
  - WR: holds `busyOut`=1 for WRITE_WAIT cycles, then 0.
    - A beat is accepted when `dataValidIn`=1 and `busyOut`=0. The SRAM is written at index+n with the latched byte enables (the same enables for every beat).
    - After each accepted beat, the wait count is reloaded.
    - After the last beat the block returns to IDLE; the initiator issues the end strobe.
  - ERROR: `busErrorOut`=1 for one cycle. No SRAM write occurs. Then IDLE.
- **Abort**: `endTransactionIn`=1 in any non-IDLE state forces IDLE next cycle.
  - All outputs go to 0 that cycle; any read beat in flight is dropped.
  - A write beat that coincides with the abort is not written.
- **Ignored begin**: `beginTransactionIn` outside IDLE is ignored.
- **Reset**: `nReset` low at any time returns the block to IDLE immediately. SRAM contents are not cleared.

## Timing
- **Reset value**: every output is 0. All outputs are registered.
- **Read reference**: begin seen in cycle T.
  - Beat n has `dataValidOut`=1 at cycle T+2+READ_WAIT+n.
  - Beats are back-to-back with no gaps.
  - `endTransactionOut`=1 at T+3+READ_WAIT+burstSize, exactly one cycle.
- **Write reference**: begin seen in cycle T.
  - `busyOut`=1 in cycles T+1..T+WRITE_WAIT.
  - The first beat can be accepted at T+1+WRITE_WAIT.
  - With WRITE_WAIT=0, `busyOut` never rises and one beat per cycle is accepted.
- **Error**: `busErrorOut`=1 at T+1 only. `dataValidOut`, `busyOut` and `endTransactionOut` stay 0.
- **Back-to-back**: a new begin is accepted in the first IDLE cycle, which is the cycle after RD_END, after the last write beat, or after ERROR.

## Test plan
- **Single write then read**: write 0xDEADBEEF to 0xC0000010 with byteEnables 4'hF and WRITE_WAIT=0, then read the same address. Required: `busyOut` stays 0; the data beat is at T+2 with 0xDEADBEEF; `endTransactionOut` is at T+3.
- **Partial write**: write 0x11223344 with byteEnables 4'b0011 over existing 0xAAAAAAAA, then read. Required: the read returns 0xAAAA3344.
- **Burst with waits**: READ_WAIT=2, a 4-beat read (burstSize=3) of preloaded words 1,2,3,4 at 0xC0000FF0. Required: valid at T+4..T+7 with 1,2,3,4; end at T+8.
- **Out of range**: a read at 0xC0001000, and a burstSize=1 read at 0xC0000FFC. Required: each gives `busErrorOut` at T+1 only, no valid beats, and then accepts a following begin.
- **Write wait and abort**: WRITE_WAIT=3 write burst with burstSize=1. Required: busy at T+1..T+3; beat 0 accepted at T+4; busy again at T+5..T+7. If `endTransactionIn` is asserted at T+6, the block returns to IDLE and beat 1 is never written.
- **Reset mid-burst**: drive `nReset` low during RD_BURST. Required: all outputs read 0 immediately, and the next begin after release is served normally.
